btb_upd_queue: RTL and testbench
================================

// Module: btb_upd_queue
// PURPOSE
//  Update stage directly upstream of the BTB write port. Buffers branch-resolution events from the
//  branch unit (clear / mispredict-retarget / new-branch) in an in-order queue.
//  Issues at most one event per cycle as single-cycle pulses on the BTB clr/mispred/new_br inputs,
//  so mispred and new_br never collide on the shared BTB write index.
//  Suppresses duplicate new-branch allocations for the same 16B fetch tag, which the BTB cannot detect.
// PARAMETERS
//  DEPTH      4                 queue entries (power of 2, >=2)
//  PC_WIDTH   `CORE_PC_WIDTH    PC / target width
//  IDX_WIDTH  `BTB_IDX_WIDTH    BTB entry index width
// PORTS
//  clk              in   1          clock
//  rst              in   1          synchronous reset, active-high
//  i_res_vld        in   1          resolution event valid
//  o_res_rdy        out  1          queue can accept (event taken when vld&rdy)
//  i_res_kind       in   2          event kind, see package encoding
//  i_res_idx        in   IDX_WIDTH  BTB index (CLR, MIS)
//  i_res_pc         in   PC_WIDTH   branch PC (NEW)
//  i_res_taddr      in   PC_WIDTH   target (MIS, NEW)
//  i_res_type       in   1          branch type (NEW)
//  i_upd_hold       in   1          BPU stalls BTB writes this cycle
//  o_btb_clr        out  1          pulse: invalidate o_btb_clr_idx
//  o_btb_clr_idx    out  IDX_WIDTH
//  o_btb_mispred    out  1          pulse: retarget o_btb_mis_idx
//  o_btb_mis_idx    out  IDX_WIDTH
//  o_btb_mis_taddr  out  PC_WIDTH
//  o_btb_new_br     out  1          pulse: allocate entry
//  o_btb_new_pc_addr out PC_WIDTH
//  o_btb_new_taddr  out  PC_WIDTH
//  o_btb_new_type   out  1
//  o_drop_cnt       out  8          saturating count of dropped events (dup NEW, kind 0)
// BEHAVIOUR
//  - Reset (sync): rd/wr pointers, count, o_drop_cnt <= 0. While rst high, o_res_rdy=0 and all o_btb_* = 0.
//    Reset mid-operation discards every queued event; nothing is issued.
//  - Accept: o_res_rdy = (count != DEPTH). No push into a full queue, even if it pops that cycle.
//  - Enqueue filter on accept:
//    - kind 0: consumed, not queued, drop_cnt+1.
//    - NEW whose pc[PC_WIDTH-1:4] equals the pc tag of any valid queued NEW entry (head included, even if
//      popping this cycle): consumed, not queued, drop_cnt+1.
//  - Latency: an event accepted at edge t is visible on o_btb_* in cycle t+1 at the earliest (no bypass).
//  - Issue: head valid & !i_upd_hold -> exactly one of clr/mispred/new_br = 1 per head kind.
//    The head pops at the end of that cycle.
//    With i_upd_hold=1 or the queue empty: all pulses 0, no pop.
//    o_btb_* data fields are 0 whenever their pulse is 0.
//  - Order strictly FIFO; no merging of CLR/MIS to the same idx.
//  - Push+pop in one cycle: count unchanged; pointers wrap modulo DEPTH.
//  - o_drop_cnt saturates at 8'hFF.
// STRUCTURE
//  - Package bpu_upd_pkg: UPD_NONE=2'd0, UPD_CLR=2'd1, UPD_MIS=2'd2, UPD_NEW=2'd3;
//    entry field layout {kind,idx,pc,taddr,type}; UPD_ENTRY_WIDTH = 2+IDX_WIDTH+2*PC_WIDTH+1.
//  - Sub-module btb_upd_fifo: storage, pointers, count, full/empty.
//    It exports per-entry valid+kind+tag for the dedup compare.
//  - The top level holds the filter, issue decode and drop counter.
// TESTING
//  1. Single NEW pc=0x1000_0024 taddr=0x1000_0100 type=1, hold=0:
//     cycle+1 new_br=1, new_pc_addr=0x1000_0024; cycle+2 all pulses 0.
//  2. hold=1, push 5 events (DEPTH=4): rdy drops after the 4th, 5th stalls.
//     Release hold: 4 pulses in push order on consecutive cycles, then the 5th.
//  3. Two NEWs pc=0x2000_0004 and 0x2000_0008 (same tag) with hold=1:
//     only one new_br is issued; drop_cnt=1.
//  4. CLR idx=3 then MIS idx=3 taddr=0x300: clr pulse (idx 3), next cycle mispred pulse (taddr 0x300).
//     Never both in the same cycle.
//  5. Queue holds 3 entries, rst=1 for one cycle: no o_btb_* pulse afterwards; rdy=1, drop_cnt=0.
//  6. Push 300 kind-0 events: drop_cnt saturates at 255; no BTB pulse.

Source files
------------

// File: rtl/bpu_upd_pkg.sv
// Shared types for the BTB update path.
// Event kind encoding and the packed queue entry layout.
package bpu_upd_pkg;

  typedef enum logic [1:0] {
    UPD_NONE = 2'd0,
    UPD_CLR  = 2'd1,
    UPD_MIS  = 2'd2,
    UPD_NEW  = 2'd3
  } upd_kind_e;

  localparam int UPD_KIND_W    = 2;
  localparam int UPD_TAG_LSB   = 4;
  localparam int DEF_IDX_WIDTH = 6;
  localparam int DEF_PC_WIDTH  = 32;

  // Entry layout, MSB first: {kind, idx, pc, taddr, type}
  function automatic int upd_entry_width(
    input int idx_w,
    input int pc_w
  );
    return UPD_KIND_W + idx_w + 2 * pc_w + 1;
  endfunction

  localparam int UPD_ENTRY_WIDTH =
    upd_entry_width(DEF_IDX_WIDTH, DEF_PC_WIDTH);

endpackage

// File: rtl/btb_upd_fifo.sv
// In-order storage for BTB update events.
// Exposes per-slot valid/kind/tag so the top can reject duplicate NEWs.
import bpu_upd_pkg::*;

module btb_upd_fifo #(
  parameter int DEPTH     = 4,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH,
  parameter int PC_WIDTH  = DEF_PC_WIDTH,
  localparam int W        = upd_entry_width(IDX_WIDTH, PC_WIDTH),
  localparam int TAG_W    = PC_WIDTH - UPD_TAG_LSB,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_wdata,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [DEPTH-1:0]       o_ent_vld,
  output logic [2*DEPTH-1:0]     o_ent_kind,
  output logic [TAG_W*DEPTH-1:0] o_ent_tag
);

  logic [W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_cnt;
  logic [DEPTH-1:0] r_vld;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == DEPTH[PTR_W:0]);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // push and pop never address the same slot: push needs !full, pop needs !empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_vld    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_ent_vld = r_vld;

  for (genvar g = 0; g < DEPTH; g++) begin : g_exp
    assign o_ent_kind[2*g +: 2] =
      r_mem[g][W-1 -: UPD_KIND_W];
    assign o_ent_tag[TAG_W*g +: TAG_W] =
      r_mem[g][2*PC_WIDTH -: TAG_W];
  end

endmodule

// File: rtl/btb_upd_queue.sv
// Update stage in front of the BTB write port: filters, queues and
// issues one resolution event per cycle as single-cycle pulses.
import bpu_upd_pkg::*;

module btb_upd_queue #(
  parameter int DEPTH     = 4,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH,
  parameter int PC_WIDTH  = DEF_PC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_res_vld,
  output logic                 o_res_rdy,
  input  logic [1:0]           i_res_kind,
  input  logic [IDX_WIDTH-1:0] i_res_idx,
  input  logic [PC_WIDTH-1:0]  i_res_pc,
  input  logic [PC_WIDTH-1:0]  i_res_taddr,
  input  logic                 i_res_type,
  input  logic                 i_upd_hold,
  output logic                 o_btb_clr,
  output logic [IDX_WIDTH-1:0] o_btb_clr_idx,
  output logic                 o_btb_mispred,
  output logic [IDX_WIDTH-1:0] o_btb_mis_idx,
  output logic [PC_WIDTH-1:0]  o_btb_mis_taddr,
  output logic                 o_btb_new_br,
  output logic [PC_WIDTH-1:0]  o_btb_new_pc_addr,
  output logic [PC_WIDTH-1:0]  o_btb_new_taddr,
  output logic                 o_btb_new_type,
  output logic [7:0]           o_drop_cnt
);

  localparam int W     = upd_entry_width(IDX_WIDTH, PC_WIDTH);
  localparam int TAG_W = PC_WIDTH - UPD_TAG_LSB;

  logic [W-1:0]           w_wdata;
  logic [W-1:0]           w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [DEPTH-1:0]       w_ent_vld;
  logic [2*DEPTH-1:0]     w_ent_kind;
  logic [TAG_W*DEPTH-1:0] w_ent_tag;

  logic             w_acc;
  logic             w_dup;
  logic             w_drop;
  logic             w_push;
  logic             w_issue;
  logic [TAG_W-1:0] w_tag;

  logic [1:0]           w_h_kind;
  logic [IDX_WIDTH-1:0] w_h_idx;
  logic [PC_WIDTH-1:0]  w_h_pc;
  logic [PC_WIDTH-1:0]  w_h_taddr;
  logic                 w_h_type;

  logic [7:0] r_drop_cnt;

  assign o_res_rdy = ~rst & ~w_full;
  assign w_acc     = i_res_vld & o_res_rdy;
  assign w_tag     = i_res_pc[PC_WIDTH-1:UPD_TAG_LSB];
  assign w_wdata   = {i_res_kind, i_res_idx, i_res_pc,
                      i_res_taddr, i_res_type};

  // the head still counts even if it pops this cycle
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i] &&
          w_ent_kind[2*i +: 2] == UPD_NEW &&
          w_ent_tag[TAG_W*i +: TAG_W] == w_tag) begin
        w_dup = 1'b1;
      end
    end
  end

  assign w_drop = w_acc &
                  ((i_res_kind == UPD_NONE) |
                   ((i_res_kind == UPD_NEW) & w_dup));
  assign w_push = w_acc & ~w_drop;

  assign w_issue = ~rst & ~w_empty & ~i_upd_hold;

  btb_upd_fifo #(
    .DEPTH     (DEPTH),
    .IDX_WIDTH (IDX_WIDTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_issue),
    .i_wdata    (w_wdata),
    .o_rdata    (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_ent_vld  (w_ent_vld),
    .o_ent_kind (w_ent_kind),
    .o_ent_tag  (w_ent_tag)
  );

  assign {w_h_kind, w_h_idx, w_h_pc,
          w_h_taddr, w_h_type} = w_head;

  always_comb begin
    o_btb_clr         = 1'b0;
    o_btb_clr_idx     = '0;
    o_btb_mispred     = 1'b0;
    o_btb_mis_idx     = '0;
    o_btb_mis_taddr   = '0;
    o_btb_new_br      = 1'b0;
    o_btb_new_pc_addr = '0;
    o_btb_new_taddr   = '0;
    o_btb_new_type    = 1'b0;
    if (w_issue) begin
      unique case (w_h_kind)
        UPD_CLR: begin
          o_btb_clr     = 1'b1;
          o_btb_clr_idx = w_h_idx;
        end
        UPD_MIS: begin
          o_btb_mispred   = 1'b1;
          o_btb_mis_idx   = w_h_idx;
          o_btb_mis_taddr = w_h_taddr;
        end
        UPD_NEW: begin
          o_btb_new_br      = 1'b1;
          o_btb_new_pc_addr = w_h_pc;
          o_btb_new_taddr   = w_h_taddr;
          o_btb_new_type    = w_h_type;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_btb_upd_queue.sv
// Scoreboard bench for btb_upd_queue: directed events, expected
// issues queued at stimulus time and checked by a negedge monitor.
module tb_btb_upd_queue;
  import bpu_upd_pkg::*;

  localparam int PCW = 32;
  localparam int IW  = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_res_vld;
  logic           o_res_rdy;
  logic [1:0]     i_res_kind;
  logic [IW-1:0]  i_res_idx;
  logic [PCW-1:0] i_res_pc;
  logic [PCW-1:0] i_res_taddr;
  logic           i_res_type;
  logic           i_upd_hold;
  logic           o_btb_clr;
  logic [IW-1:0]  o_btb_clr_idx;
  logic           o_btb_mispred;
  logic [IW-1:0]  o_btb_mis_idx;
  logic [PCW-1:0] o_btb_mis_taddr;
  logic           o_btb_new_br;
  logic [PCW-1:0] o_btb_new_pc_addr;
  logic [PCW-1:0] o_btb_new_taddr;
  logic           o_btb_new_type;
  logic [7:0]     o_drop_cnt;

  always #5 clk = ~clk;

  btb_upd_queue #(
    .DEPTH     (4),
    .IDX_WIDTH (IW),
    .PC_WIDTH  (PCW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_res_vld         (i_res_vld),
    .o_res_rdy         (o_res_rdy),
    .i_res_kind        (i_res_kind),
    .i_res_idx         (i_res_idx),
    .i_res_pc          (i_res_pc),
    .i_res_taddr       (i_res_taddr),
    .i_res_type        (i_res_type),
    .i_upd_hold        (i_upd_hold),
    .o_btb_clr         (o_btb_clr),
    .o_btb_clr_idx     (o_btb_clr_idx),
    .o_btb_mispred     (o_btb_mispred),
    .o_btb_mis_idx     (o_btb_mis_idx),
    .o_btb_mis_taddr   (o_btb_mis_taddr),
    .o_btb_new_br      (o_btb_new_br),
    .o_btb_new_pc_addr (o_btb_new_pc_addr),
    .o_btb_new_taddr   (o_btb_new_taddr),
    .o_btb_new_type    (o_btb_new_type),
    .o_drop_cnt        (o_drop_cnt)
  );

  typedef struct {
    logic [1:0]     kind;
    logic [IW-1:0]  idx;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] taddr;
    logic           typ;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic accept();
    for (int k = 0; k < 20; k++) begin
      if (o_res_rdy) begin
        @(posedge clk);
        #1;
        i_res_vld = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    n_fail++;
    $display("FAIL accept_timeout: got rdy=0 want rdy=1");
    i_res_vld = 1'b0;
  endtask

  task automatic drive(input logic [1:0] kind,
                       input logic [IW-1:0] idx,
                       input logic [PCW-1:0] pc,
                       input logic [PCW-1:0] taddr,
                       input logic typ,
                       input bit expect_issue);
    exp_t e;
    i_res_kind  = kind;
    i_res_idx   = idx;
    i_res_pc    = pc;
    i_res_taddr = taddr;
    i_res_type  = typ;
    i_res_vld   = 1'b1;
    if (expect_issue) begin
      e.kind  = kind;
      e.idx   = idx;
      e.pc    = pc;
      e.taddr = taddr;
      e.typ   = typ;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [1:0] kind,
                      input logic [IW-1:0] idx,
                      input logic [PCW-1:0] pc,
                      input logic [PCW-1:0] taddr,
                      input logic typ,
                      input bit expect_issue);
    drive(kind, idx, pc, taddr, typ, expect_issue);
    accept();
  endtask

  // monitor: every pulse must match the scoreboard head, in order
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] p;
    logic       stray;
    p = {o_btb_clr, o_btb_mispred, o_btb_new_br};
    if (!rst) begin
      stray = (!o_btb_clr && o_btb_clr_idx != 0) ||
              (!o_btb_mispred && (o_btb_mis_idx != 0 ||
                                  o_btb_mis_taddr != 0)) ||
              (!o_btb_new_br && (o_btb_new_pc_addr != 0 ||
                                 o_btb_new_taddr != 0 ||
                                 o_btb_new_type != 0));
      chk("idle_fields_zero", 64'(stray), 64'd0);
    end
    if (p != 3'b000) begin
      chk("pulse_onehot", 64'($onehot(p)), 64'd1);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %b want none", p);
      end else begin
        e = exp_q.pop_front();
        if (o_btb_clr) begin
          chk("clr_kind", 64'(UPD_CLR), 64'(e.kind));
          chk("clr_idx", 64'(o_btb_clr_idx), 64'(e.idx));
        end else if (o_btb_mispred) begin
          chk("mis_kind", 64'(UPD_MIS), 64'(e.kind));
          chk("mis_idx", 64'(o_btb_mis_idx), 64'(e.idx));
          chk("mis_taddr", 64'(o_btb_mis_taddr),
              64'(e.taddr));
        end else begin
          chk("new_kind", 64'(UPD_NEW), 64'(e.kind));
          chk("new_pc", 64'(o_btb_new_pc_addr), 64'(e.pc));
          chk("new_taddr", 64'(o_btb_new_taddr),
              64'(e.taddr));
          chk("new_type", 64'(o_btb_new_type), 64'(e.typ));
        end
      end
    end
  end

  function automatic logic [2:0] pulses();
    return {o_btb_clr, o_btb_mispred, o_btb_new_br};
  endfunction

  initial begin
    rst         = 1'b1;
    i_res_vld   = 1'b0;
    i_res_kind  = 2'd0;
    i_res_idx   = '0;
    i_res_pc    = '0;
    i_res_taddr = '0;
    i_res_type  = 1'b0;
    i_upd_hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(o_res_rdy), 64'd0);
    chk("rst_drop", 64'(o_drop_cnt), 64'd0);
    chk("rst_pulses", 64'(pulses()), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(o_res_rdy), 64'd1);

    // single NEW: visible the cycle after accept, gone after
    send(UPD_NEW, 6'd0, 32'h1000_0024, 32'h1000_0100, 1'b1, 1);
    chk("t1_new_br", 64'(o_btb_new_br), 64'd1);
    chk("t1_new_pc", 64'(o_btb_new_pc_addr), 64'h1000_0024);
    @(posedge clk);
    #1;
    chk("t1_after", 64'(pulses()), 64'd0);

    // fill under hold, fifth stalls, then drain in order
    i_upd_hold = 1'b1;
    send(UPD_CLR, 6'd1, 32'h0, 32'h0, 1'b0, 1);
    send(UPD_MIS, 6'd2, 32'h0, 32'h200, 1'b0, 1);
    send(UPD_NEW, 6'd0, 32'h3000_0010, 32'h3000_0400, 1'b0, 1);
    chk("t2_rdy_3", 64'(o_res_rdy), 64'd1);
    send(UPD_CLR, 6'd4, 32'h0, 32'h0, 1'b0, 1);
    chk("t2_rdy_full", 64'(o_res_rdy), 64'd0);
    drive(UPD_MIS, 6'd5, 32'h0, 32'h500, 1'b0, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("t2_stall_rdy", 64'(o_res_rdy), 64'd0);
      chk("t2_hold_pulses", 64'(pulses()), 64'd0);
    end
    i_upd_hold = 1'b0;
    fork
      accept();
      begin
        repeat (5) begin
          @(negedge clk);
          chk("t2_consecutive", 64'(pulses() != 0), 64'd1);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // duplicate NEW tag is dropped
    i_upd_hold = 1'b1;
    send(UPD_NEW, 6'd0, 32'h2000_0004, 32'h2000_0100, 1'b0, 1);
    send(UPD_NEW, 6'd0, 32'h2000_0008, 32'h2000_0200, 1'b1, 0);
    chk("t3_drop", 64'(o_drop_cnt), 64'd1);
    i_upd_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // CLR then MIS to the same index, separate cycles
    send(UPD_CLR, 6'd3, 32'h0, 32'h0, 1'b0, 1);
    chk("t4_clr", 64'(pulses()), 64'b100);
    chk("t4_clr_idx", 64'(o_btb_clr_idx), 64'd3);
    send(UPD_MIS, 6'd3, 32'h0, 32'h300, 1'b0, 1);
    chk("t4_mis", 64'(pulses()), 64'b010);
    chk("t4_mis_taddr", 64'(o_btb_mis_taddr), 64'h300);
    @(posedge clk);
    #1;

    // reset discards queued events
    i_upd_hold = 1'b1;
    send(UPD_CLR, 6'd7, 32'h0, 32'h0, 1'b0, 0);
    send(UPD_MIS, 6'd8, 32'h0, 32'h800, 1'b0, 0);
    send(UPD_NEW, 6'd0, 32'h4000_0000, 32'h4000_0040, 1'b1, 0);
    i_upd_hold = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_rdy", 64'(o_res_rdy), 64'd0);
    chk("t5_rst_pulses", 64'(pulses()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_rdy", 64'(o_res_rdy), 64'd1);
    chk("t5_drop", 64'(o_drop_cnt), 64'd0);
    repeat (5) @(posedge clk);
    #1;

    // kind-0 events saturate the drop counter
    for (int i = 0; i < 300; i++) begin
      send(UPD_NONE, 6'(i), 32'(i), 32'(i), 1'b0, 0);
    end
    chk("t6_drop_sat", 64'(o_drop_cnt), 64'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk("end_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
